// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory-access stage of the five-stage pipeline. Runs a
//               request/acknowledge data-bus transaction for loads and
//               stores, aligns store data and strobes, extracts and extends
//               load data, and passes non-memory instructions straight
//               through to MEM/WB in the same cycle.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_*                - EX/MEM pipeline register contents
//               out_*               - MEM/WB pipeline register inputs
//               ale                 - address-misaligned exception flag
//               stall_req           - holds EX/MEM and all earlier stages
//               dbus_*              - data-bus request/response channel
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic [3:0]  in_mem_op,
    input  logic [4:0]  in_rw_addr,
    input  logic        in_rw_en,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_rw_data,
    output logic [4:0]  out_rw_addr,
    output logic        out_rw_en,
    output logic        ale,
    output logic        stall_req,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_LD_B  = 4'd1;
    localparam logic [3:0] c_OP_LD_H  = 4'd2;
    localparam logic [3:0] c_OP_LD_W  = 4'd3;
    localparam logic [3:0] c_OP_LD_BU = 4'd4;
    localparam logic [3:0] c_OP_LD_HU = 4'd5;
    localparam logic [3:0] c_OP_ST_B  = 4'd6;
    localparam logic [3:0] c_OP_ST_H  = 4'd7;
    localparam logic [3:0] c_OP_ST_W  = 4'd8;

    state_t      state_q, state_d;
    logic [31:0] ldata_q, ldata_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_mem_active;
    logic        w_misaligned;
    logic        w_mem_go;
    logic [1:0]  w_lane;

    assign w_lane       = in_alu_result[1:0];
    assign w_is_load    = (in_mem_op >= c_OP_LD_B) && (in_mem_op <= c_OP_LD_HU);
    assign w_is_store   = (in_mem_op >= c_OP_ST_B) && (in_mem_op <= c_OP_ST_W);
    assign w_is_half    = (in_mem_op == c_OP_LD_H) || (in_mem_op == c_OP_LD_HU) ||
                          (in_mem_op == c_OP_ST_H);
    assign w_is_word    = (in_mem_op == c_OP_LD_W) || (in_mem_op == c_OP_ST_W);
    assign w_mem_active = in_valid && (w_is_load || w_is_store);
    assign w_misaligned = (w_is_half && w_lane[0]) || (w_is_word && (w_lane != 2'b00));
    assign w_mem_go     = w_mem_active && !w_misaligned;

    // ------------------------------------------------------------------
    // Store alignment: data is replicated across lanes, strobes pick lanes
    // ------------------------------------------------------------------
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;

    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = 32'h0;
        case (in_mem_op)
            c_OP_ST_B: begin
                w_strb  = 4'b0001 << w_lane;
                w_wdata = {4{in_store_data[7:0]}};
            end
            c_OP_ST_H: begin
                w_strb  = 4'b0011 << {w_lane[1], 1'b0};
                w_wdata = {2{in_store_data[15:0]}};
            end
            c_OP_ST_W: begin
                w_strb  = 4'hF;
                w_wdata = in_store_data;
            end
            default: begin
                w_strb  = 4'b0000;
                w_wdata = 32'h0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction from the captured word
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

    always_comb begin
        case (w_lane)
            2'd0:    w_byte = ldata_q[7:0];
            2'd1:    w_byte = ldata_q[15:8];
            2'd2:    w_byte = ldata_q[23:16];
            default: w_byte = ldata_q[31:24];
        endcase
        w_half = w_lane[1] ? ldata_q[31:16] : ldata_q[15:0];
        case (in_mem_op)
            c_OP_LD_B:  w_load_val = {{24{w_byte[7]}}, w_byte};
            c_OP_LD_H:  w_load_val = {{16{w_half[15]}}, w_half};
            c_OP_LD_BU: w_load_val = {24'h0, w_byte};
            c_OP_LD_HU: w_load_val = {16'h0, w_half};
            default:    w_load_val = ldata_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ldata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ldata_q <= ldata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ldata_d     = ldata_q;
        out_pc      = 32'h0;
        out_inst    = 32'h0;
        out_rw_data = 32'h0;
        out_rw_addr = 5'd0;
        out_rw_en   = 1'b0;
        ale         = 1'b0;
        stall_req   = 1'b0;
        dbus_req    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_mem_go) begin
                    dbus_req  = 1'b1;
                    stall_req = 1'b1;
                    if (dbus_ack) begin
                        state_d = w_is_store ? S_DONE : S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    // Pass-through; a misaligned access flags ale and
                    // suppresses its writeback but still carries pc/inst.
                    out_pc      = in_pc;
                    out_inst    = in_inst;
                    out_rw_data = in_alu_result;
                    out_rw_addr = in_rw_addr;
                    if (w_mem_active) begin
                        ale = 1'b1;
                    end else begin
                        out_rw_en = in_rw_en && in_valid;
                    end
                end
            end
            S_REQ: begin
                dbus_req  = 1'b1;
                stall_req = 1'b1;
                if (dbus_ack) begin
                    state_d = w_is_store ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall_req = 1'b1;
                if (dbus_rvalid) begin
                    ldata_d = dbus_rdata;
                    state_d = S_DONE;
                end
            end
            default: begin
                // DONE: EX/MEM advances on this edge, so return to IDLE.
                state_d     = S_IDLE;
                out_pc      = in_pc;
                out_inst    = in_inst;
                out_rw_addr = in_rw_addr;
                out_rw_data = w_is_load ? w_load_val : in_alu_result;
                out_rw_en   = w_is_load && in_rw_en && in_valid;
            end
        endcase

        // Bus fields are meaningful only while a request is presented.
        dbus_we    = dbus_req && w_is_store;
        dbus_addr  = dbus_req ? {in_alu_result[31:2], 2'b00} : 32'h0;
        dbus_wstrb = dbus_req ? w_strb : 4'b0000;
        dbus_wdata = dbus_req ? w_wdata : 32'h0;

        if (rst) begin
            out_pc      = 32'h0;
            out_inst    = 32'h0;
            out_rw_data = 32'h0;
            out_rw_addr = 5'd0;
            out_rw_en   = 1'b0;
            ale         = 1'b0;
            stall_req   = 1'b0;
            dbus_req    = 1'b0;
            dbus_we     = 1'b0;
            dbus_addr   = 32'h0;
            dbus_wstrb  = 4'b0000;
            dbus_wdata  = 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage with directed
//               scenarios and randomized transactions against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [3:0]  in_mem_op;
    logic [4:0]  in_rw_addr;
    logic        in_rw_en;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_rw_data;
    logic [4:0]  out_rw_addr;
    logic        out_rw_en;
    logic        ale;
    logic        stall_req;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    int checks   = 0;
    int failures = 0;

    mem_access_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_alu_result(in_alu_result),
        .in_store_data(in_store_data),
        .in_mem_op    (in_mem_op),
        .in_rw_addr   (in_rw_addr),
        .in_rw_en     (in_rw_en),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_rw_data  (out_rw_data),
        .out_rw_addr  (out_rw_addr),
        .out_rw_en    (out_rw_en),
        .ale          (ale),
        .stall_req    (stall_req),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_wstrb   (dbus_wstrb),
        .dbus_wdata   (dbus_wdata),
        .dbus_ack     (dbus_ack),
        .dbus_rvalid  (dbus_rvalid),
        .dbus_rdata   (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input logic [3:0] op);
        return (op >= 1) && (op <= 5);
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return (op >= 6) && (op <= 8);
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
        if (op == 2 || op == 5 || op == 7) return (a % 2) != 0;
        if (op == 3 || op == 8)            return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) % 256;
        h = (w >> (16 * ((a / 2) % 2))) % 65536;
        case (op)
            4'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            4'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4'd4:    return b;
            4'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [31:0] a);
        if (op == 6) return 4'(1 << (a % 4));
        if (op == 7) return 4'(3 << (2 * ((a / 2) % 2)));
        if (op == 8) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        if (op == 6) return (d % 256) * 32'h0101_0101;
        if (op == 7) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h1;
        in_alu_result = 32'h55; in_store_data = 32'h0; in_mem_op = 4'd0;
        in_rw_addr = 5'd3; in_rw_en = 1'b1;
        dbus_ack = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({out_pc, out_inst, out_rw_data, out_rw_addr, out_rw_en, ale, stall_req,
                 dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: pc=%h rw_data=%h rw_en=%b req=%b, required all zero",
                         out_pc, out_rw_data, out_rw_en, dbus_req);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One instruction through the stage; checks every cycle until it retires.
    task automatic test_mem_transaction(input logic valid, input logic [3:0] op,
                                        input logic [31:0] addr, input logic [31:0] sdata,
                                        input logic [31:0] rdata, input int ack_dly,
                                        input int rv_dly, input logic [4:0] rwa,
                                        input logic rwe);
        bit active, mis, ld, st;
        int last;
        logic [31:0] pc, inst;
        pc = $urandom; inst = $urandom;
        ld = m_is_load(op); st = m_is_store(op);
        active = valid && (ld || st);
        mis    = active && m_misaligned(op, addr);
        in_valid = valid; in_mem_op = op; in_alu_result = addr; in_store_data = sdata;
        in_pc = pc; in_inst = inst; in_rw_addr = rwa; in_rw_en = rwe;

        if (!active || mis) begin
            dbus_ack = $urandom_range(0, 1); dbus_rvalid = $urandom_range(0, 1);
            dbus_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({stall_req, dbus_req, ale} !== {2'b00, mis}) begin
                failures++;
                $display("FAIL passthru_ctrl: stall/req/ale=%b%b%b required %b%b%b op=%0d a=%h",
                         stall_req, dbus_req, ale, 1'b0, 1'b0, mis, op, addr);
            end
            checks++;
            if ({out_pc, out_inst, out_rw_en} !== {pc, inst, mis ? 1'b0 : (rwe & valid)} ||
                (!mis && {out_rw_addr, out_rw_data} !== {rwa, addr})) begin
                failures++;
                $display("FAIL passthru_data: pc=%h inst=%h en=%b wa=%0d wd=%h required %h %h %b %0d %h",
                         out_pc, out_inst, out_rw_en, out_rw_addr, out_rw_data,
                         pc, inst, mis ? 1'b0 : (rwe & valid), rwa, addr);
            end
            @(posedge clk); #1;
            dbus_ack = 1'b0; dbus_rvalid = 1'b0;
            return;
        end

        last = ld ? ack_dly + rv_dly + 2 : ack_dly + 1;
        for (int cyc = 0; cyc <= last; cyc++) begin
            bit in_req, in_wait;
            logic [70:0] exp_bus, obs_bus;
            in_req  = (cyc <= ack_dly);
            in_wait = ld && (cyc > ack_dly) && (cyc < last);
            // Bus response with noise that the stage must ignore.
            dbus_ack    = in_req ? (cyc == ack_dly) : 1'($urandom_range(0, 1));
            dbus_rvalid = in_wait ? (cyc == last - 1) :
                          ((cyc < ack_dly) ? 1'($urandom_range(0, 1)) : 1'b0);
            dbus_rdata  = (in_wait && cyc == last - 1) ? rdata : $urandom;
            @(negedge clk);
            exp_bus = in_req ? {2'b11, st, m_strb(op, addr), addr & 32'hFFFF_FFFC,
                                st ? m_wdata(op, sdata) : 32'h0}
                             : {in_wait, 70'h0};
            obs_bus = {stall_req, dbus_req, dbus_we, dbus_wstrb, dbus_addr,
                       st ? dbus_wdata : 32'h0};
            checks++;
            if (obs_bus !== exp_bus) begin
                failures++;
                $display("FAIL bus_cycle%0d: got %h required %h op=%0d a=%h",
                         cyc, obs_bus, exp_bus, op, addr);
            end
            if (cyc < last) begin
                checks++;
                if ({out_pc, out_inst, out_rw_en, out_rw_addr, out_rw_data, ale} !== '0) begin
                    failures++;
                    $display("FAIL bubble_cycle%0d: pc=%h inst=%h en=%b wa=%0d wd=%h ale=%b required zeros",
                             cyc, out_pc, out_inst, out_rw_en, out_rw_addr, out_rw_data, ale);
                end
            end else begin
                logic [31:0] exp_wd;
                exp_wd = ld ? m_load(op, addr, rdata) : out_rw_data;
                checks++;
                if ({out_pc, out_inst, out_rw_en, out_rw_addr, ale} !== {pc, inst, ld & rwe, rwa, 1'b0} ||
                    (ld && out_rw_data !== exp_wd)) begin
                    failures++;
                    $display("FAIL done_outputs: pc=%h en=%b wa=%0d wd=%h required pc=%h en=%b wa=%0d wd=%h op=%0d a=%h",
                             out_pc, out_rw_en, out_rw_addr, out_rw_data,
                             pc, ld & rwe, rwa, exp_wd, op, addr);
                end
            end
            @(posedge clk); #1;
        end
        dbus_ack = 1'b0; dbus_rvalid = 1'b0;
    endtask

    task automatic test_alu;
        test_mem_transaction(1'b1, 4'd0, 32'h1234, 32'h0, 32'h0, 0, 0, 5'd5, 1'b1);
        test_mem_transaction(1'b1, 4'd12, 32'hCAFE_0001, 32'h0, 32'h0, 0, 0, 5'd9, 1'b1);
        test_mem_transaction(1'b0, 4'd3, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 5'd7, 1'b1);
    endtask

    task automatic test_load_byte;
        test_mem_transaction(1'b1, 4'd1, 32'h1003, 32'h0, 32'h80FF_FF7F, 0, 0, 5'd4, 1'b1);
        test_mem_transaction(1'b1, 4'd4, 32'h1003, 32'h0, 32'h80FF_FF7F, 0, 0, 5'd4, 1'b1);
        test_mem_transaction(1'b1, 4'd2, 32'h1002, 32'h0, 32'h8001_7FFF, 1, 2, 5'd6, 1'b1);
    endtask

    task automatic test_store_half;
        test_mem_transaction(1'b1, 4'd7, 32'h2002, 32'hAAAA_BEEF, 32'h0, 3, 0, 5'd0, 1'b0);
        test_mem_transaction(1'b1, 4'd6, 32'h2001, 32'h1234_56A5, 32'h0, 0, 0, 5'd0, 1'b0);
    endtask

    task automatic test_misaligned;
        test_mem_transaction(1'b1, 4'd3, 32'h3001, 32'h0, 32'h0, 0, 0, 5'd8, 1'b1);
        test_mem_transaction(1'b1, 4'd8, 32'h3002, 32'h0, 32'h0, 0, 0, 5'd0, 1'b0);
        test_mem_transaction(1'b1, 4'd5, 32'h3003, 32'h0, 32'h0, 0, 0, 5'd8, 1'b1);
    endtask

    task automatic test_reset_mid_wait;
        in_valid = 1'b1; in_mem_op = 4'd3; in_alu_result = 32'h40; in_rw_en = 1'b1;
        in_rw_addr = 5'd2; dbus_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_issue: dbus_req=%b required 1", dbus_req);
        end
        @(posedge clk); #1;
        dbus_ack = 1'b0; rst = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({stall_req, dbus_req, out_rw_en, out_rw_data} !== '0) begin
            failures++;
            $display("FAIL rst_wait_outputs: stall=%b req=%b en=%b wd=%h required zeros",
                     stall_req, dbus_req, out_rw_en, out_rw_data);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall_req, dbus_req, out_rw_en} !== 3'b000) begin
            failures++;
            $display("FAIL rst_late_rvalid: stall/req/en=%b%b%b required 000",
                     stall_req, dbus_req, out_rw_en);
        end
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.ldata_q !== 32'h0) begin
            failures++;
            $display("FAIL rst_ldata: ldata=%h required 00000000", dut.ldata_q);
        end
        @(posedge clk); #1;
        // A fresh aligned load must be issued from IDLE right away.
        test_mem_transaction(1'b1, 4'd3, 32'h44, 32'h0, 32'h1357_9BDF, 0, 0, 5'd3, 1'b1);
    endtask

    task automatic test_back_to_back;
        test_mem_transaction(1'b1, 4'd3, 32'h500, 32'h0, 32'h0102_0304, 0, 2, 5'd10, 1'b1);
        test_mem_transaction(1'b1, 4'd8, 32'h504, 32'hFEED_F00D, 32'h0, 0, 2, 5'd0, 1'b0);
        test_mem_transaction(1'b1, 4'd3, 32'h508, 32'h0, 32'hA5A5_5A5A, 0, 2, 5'd11, 1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 8));
            a = $urandom;
            test_mem_transaction(($urandom_range(0, 7) != 0), op, a, $urandom, $urandom,
                                 $urandom_range(0, 3), $urandom_range(0, 3),
                                 5'($urandom), m_is_store(op) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load_byte;
        test_store_half;
        test_misaligned;
        test_reset_mid_wait;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
